// File: rtl/bg_blitter_pkg.sv
// Shared definitions for the ROM-to-framebuffer blitter: blit modes and FSM states.
package bg_blitter_pkg;

  localparam logic [1:0] MODE_OPAQUE = 2'b00;
  localparam logic [1:0] MODE_KEYED  = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Raster scan counters for the blitter: image column/row and the matching linear ROM address.
module blit_addr_gen #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    cx,
  output logic [Y_W-1:0]    cy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic cx_end;

  assign cx_end = (cx == X_W'(IMG_W - 1));
  assign last   = cx_end && (cy == Y_W'(IMG_H - 1));

  // addr tracks cy*IMG_W+cx incrementally, so no multiplier is needed
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx   <= '0;
      cy   <= '0;
      addr <= '0;
    end else if (clear) begin
      cx   <= '0;
      cy   <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (cx_end) begin
        cx <= '0;
        cy <= cy + Y_W'(1);
      end else begin
        cx <= cx + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/bg_blitter.sv
// Streams an IMG_W x IMG_H image from a synchronous ROM to the vga_adapter plot port,
// with opaque, colour-keyed and fill modes, screen clipping and abort.
module bg_blitter
  import bg_blitter_pkg::*;
#(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int ADDR_W   = 15,
  parameter int ROM_LAT  = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [COLOR_W-1:0] key_colour,
  input  logic [COLOR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [X_W-1:0]     out_x,
  output logic [Y_W-1:0]     out_y,
  output logic [COLOR_W-1:0] out_colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] SCR_W = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W + 1)'(SCREEN_H);

  state_t state, state_nxt;

  logic [1:0]         mode_l;
  logic [X_W-1:0]     x0_l;
  logic [Y_W-1:0]     y0_l;
  logic [COLOR_W-1:0] key_l;
  logic [COLOR_W-1:0] fill_l;
  logic [1:0]         drain_cnt;

  logic               accept;
  logic               cancel;
  logic               last;
  logic [X_W-1:0]     cx;
  logic [Y_W-1:0]     cy;

  logic [ROM_LAT-1:0] v_d;
  logic [X_W-1:0]     cx_d [ROM_LAT];
  logic [Y_W-1:0]     cy_d [ROM_LAT];

  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;
  logic               keyed_hit;
  logic [COLOR_W-1:0] pix_colour;
  logic [X_W-1:0]     hold_x;
  logic [Y_W-1:0]     hold_y;
  logic [COLOR_W-1:0] hold_colour;

  assign accept = (state == ST_IDLE) && start && !abort;
  assign cancel = abort && ((state == ST_RUN) || (state == ST_DRAIN));

  blit_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clock  (clock),
    .resetn (resetn),
    .clear  (accept),
    .advance((state == ST_RUN) && !last),
    .cx     (cx),
    .cy     (cy),
    .addr   (rom_addr),
    .last   (last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_RUN;
      ST_RUN:   if (abort) state_nxt = ST_IDLE;
                else if (last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (abort) state_nxt = ST_IDLE;
                else if (drain_cnt == 2'(ROM_LAT - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Blit parameters are frozen at start so the controller may change its inputs mid-blit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_l <= MODE_OPAQUE;
      x0_l   <= '0;
      y0_l   <= '0;
      key_l  <= '0;
      fill_l <= '0;
    end else if (accept) begin
      mode_l <= mode;
      x0_l   <= x0;
      y0_l   <= y0;
      key_l  <= key_colour;
      fill_l <= fill_colour;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v_d <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        cx_d[i] <= '0;
        cy_d[i] <= '0;
      end
    end else begin
      v_d[0]  <= (state == ST_RUN) && !cancel;
      cx_d[0] <= cx;
      cy_d[0] <= cy;
      for (int i = 1; i < ROM_LAT; i++) begin
        v_d[i]  <= v_d[i-1] && !cancel;
        cx_d[i] <= cx_d[i-1];
        cy_d[i] <= cy_d[i-1];
      end
    end
  end

  // Pixel stage meets rom_q in the same cycle so a pixel is plotted exactly ROM_LAT cycles after its address
  assign sum_x      = {1'b0, x0_l} + {1'b0, cx_d[ROM_LAT-1]};
  assign sum_y      = {1'b0, y0_l} + {1'b0, cy_d[ROM_LAT-1]};
  assign keyed_hit  = (mode_l == MODE_KEYED) && (rom_q == key_l);
  assign pix_colour = (mode_l == MODE_FILL) ? fill_l : rom_q;
  assign plot       = v_d[ROM_LAT-1] && (sum_x < SCR_W) && (sum_y < SCR_H) && !keyed_hit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hold_x      <= '0;
      hold_y      <= '0;
      hold_colour <= '0;
    end else if (plot) begin
      hold_x      <= sum_x[X_W-1:0];
      hold_y      <= sum_y[Y_W-1:0];
      hold_colour <= pix_colour;
    end
  end

  assign out_x      = plot ? sum_x[X_W-1:0] : hold_x;
  assign out_y      = plot ? sum_y[Y_W-1:0] : hold_y;
  assign out_colour = plot ? pix_colour : hold_colour;
  assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
  assign done       = (state == ST_DONE);

endmodule
